// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first.
// Optional signed-overflow output when SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ov
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             x, y, diff, br_next;
`ifdef SUB_OVERFLOW_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ov_q, ov_d;
`endif

  // Full-subtractor cell on the current LSBs plus the borrow flop.
  always_comb begin
    x       = a_sr_q[0];
    y       = b_sr_q[0];
    diff    = x ^ y ^ br_q;
    br_next = (~x & y) | (~(x ^ y) & br_q);
  end

  // Next-state, shift-register and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SUB_OVERFLOW_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ov_d    = ov_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
`ifdef SUB_OVERFLOW_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_d    = {diff, r_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          bo_d    = br_next;
`ifdef SUB_OVERFLOW_EN
          ov_d    = (amsb_q ^ bmsb_q) & (amsb_q ^ diff);
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVERFLOW_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ov_q    <= ov_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = r_q;
  assign bo   = bo_q;
`ifdef SUB_OVERFLOW_EN
  assign ov   = ov_q;
`endif

endmodule
